// File: rtl/video_delta_scheduler.sv
`timescale 1ns/1ps
// video_delta_scheduler
//   Arbitrates the single delta-input port of the ATOMiK core between the
//   camera frame-delta source and the host command path. Each requester owns
//   a one-entry holding slot. Grants alternate round-robin when both slots
//   are full, and the core is driven over a valid/ready handshake.
//
//   The camera cannot be stalled. A strobe that arrives while its slot is
//   still occupied is an overflow. Every overflow bumps a saturating event
//   counter.
//
//   Compile-time option:
//     DELTA_COALESCE_EN  defined   : an overflowing delta is XOR-merged into
//                                    the held delta. The core accumulates by
//                                    XOR, so the merged word is equivalent to
//                                    applying both deltas.
//     DELTA_COALESCE_EN  undefined : an overflowing delta is dropped and the
//                                    older held value is kept.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cam_delta, cam_ready        camera delta and its single-cycle strobe
//   host_valid/ready/op/delta   host request handshake, opcode and operand
//   core_valid/ready/op/data    request to the core
//   core_src                    source of the request: 0 = camera, 1 = host
//   event_count, cnt_clr        saturating overflow counter and its
//                               synchronous clear
//   busy                        a slot is full or a core request is pending
module video_delta_scheduler #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cam_delta,
  input  logic                  cam_ready,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [1:0]            host_op,
  input  logic [DATA_WIDTH-1:0] host_delta,
  output logic                  core_valid,
  input  logic                  core_ready,
  output logic [1:0]            core_op,
  output logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_src,
  output logic [CNT_WIDTH-1:0]  event_count,
  input  logic                  cnt_clr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT_CAM, GRANT_HOST} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_reg;
  logic                    last_grant_reg;   // 1 = host was granted last
  logic                    cam_full_reg;
  logic [DATA_WIDTH-1:0]   cam_buf_reg;
  logic                    host_full_reg;
  logic [DATA_WIDTH-1:0]   host_buf_reg;
  logic [1:0]              host_opbuf_reg;
  logic                    core_valid_reg;
  logic [1:0]              core_op_reg;
  logic [DATA_WIDTH-1:0]   core_data_reg;
  logic                    core_src_reg;
  logic [CNT_WIDTH-1:0]    event_count_reg;

  logic grant_cam;
  logic grant_host;
  logic host_accept;
  logic cam_overflow;

  // The camera wins a tie only when the host was served last.
  assign grant_cam    = (state_reg == IDLE) && cam_full_reg &&
                        (!host_full_reg || last_grant_reg);
  assign grant_host   = (state_reg == IDLE) && host_full_reg && !grant_cam;
  assign host_accept  = host_valid && !host_full_reg;
  // A slot that is being granted on this edge is free for the new strobe.
  assign cam_overflow = cam_ready && cam_full_reg && !grant_cam;

  assign host_ready  = !host_full_reg;
  assign core_valid  = core_valid_reg;
  assign core_op     = core_op_reg;
  assign core_data   = core_data_reg;
  assign core_src    = core_src_reg;
  assign event_count = event_count_reg;
  assign busy        = cam_full_reg || host_full_reg || core_valid_reg;

  // Camera holding slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_full_reg <= 1'b0;
      cam_buf_reg  <= '0;
    end else if (cam_ready) begin
      if (!cam_full_reg || grant_cam) begin
        cam_full_reg <= 1'b1;
        cam_buf_reg  <= cam_delta;
      end else begin
`ifdef DELTA_COALESCE_EN
        cam_buf_reg <= cam_buf_reg ^ cam_delta;
`else
        cam_buf_reg <= cam_buf_reg;
`endif
      end
    end else if (grant_cam) begin
      cam_full_reg <= 1'b0;
    end
  end

  // Host holding slot. host_ready is low while the slot is full, so an
  // accept and a grant never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_full_reg  <= 1'b0;
      host_buf_reg   <= '0;
      host_opbuf_reg <= 2'b00;
    end else if (host_accept) begin
      host_full_reg  <= 1'b1;
      host_buf_reg   <= host_delta;
      host_opbuf_reg <= host_op;
    end else if (grant_host) begin
      host_full_reg <= 1'b0;
    end
  end

  // Grant FSM with registered core-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      core_valid_reg <= 1'b0;
      core_op_reg    <= 2'b00;
      core_data_reg  <= '0;
      core_src_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_cam) begin
            core_data_reg  <= cam_buf_reg;
            core_op_reg    <= 2'b00;
            core_src_reg   <= 1'b0;
            core_valid_reg <= 1'b1;
            last_grant_reg <= 1'b0;
            state_reg      <= GRANT_CAM;
          end else if (grant_host) begin
            core_data_reg  <= host_buf_reg;
            core_op_reg    <= host_opbuf_reg;
            core_src_reg   <= 1'b1;
            core_valid_reg <= 1'b1;
            last_grant_reg <= 1'b1;
            state_reg      <= GRANT_HOST;
          end
        end
        GRANT_CAM, GRANT_HOST: begin
          if (core_ready) begin
            core_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          core_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  // Overflow counter: the clear wins over a same-cycle increment, and the
  // count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count_reg <= '0;
    end else if (cnt_clr) begin
      event_count_reg <= '0;
    end else if (cam_overflow && (event_count_reg != CNT_MAX)) begin
      event_count_reg <= event_count_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_video_delta_scheduler.sv
`timescale 1ns/1ps
module tb_video_delta_scheduler;
  localparam int DW = 256;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          src;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] cam_delta;
  logic          cam_ready;
  logic          host_valid;
  logic          host_ready;
  logic [1:0]    host_op;
  logic [DW-1:0] host_delta;
  logic          core_valid;
  logic          core_ready;
  logic [1:0]    core_op;
  logic [DW-1:0] core_data;
  logic          core_src;
  logic [CW-1:0] event_count;
  logic          cnt_clr;
  logic          busy;

  int   n_cmp = 0;
  int   n_err = 0;
  txn_t sb[$];

  video_delta_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_delta(cam_delta), .cam_ready(cam_ready),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_op(host_op), .host_delta(host_delta),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_op(core_op), .core_data(core_data), .core_src(core_src),
    .event_count(event_count), .cnt_clr(cnt_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: sample the core handshake on the falling edge (it completes
  // on the following rising edge), then return just after that rising edge.
  task automatic tick();
    txn_t e;
    @(negedge clk);
    if (rst_n && core_valid && core_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL txn_unexpected: got op=%0h src=%0d data=%0h, required no transaction",
                 core_op, core_src, core_data);
      end else begin
        e = sb.pop_front();
        if (core_op !== e.op || core_data !== e.data || core_src !== e.src) begin
          n_err++;
          $display("FAIL txn: got op=%0h src=%0d data=%0h, required op=%0h src=%0d data=%0h",
                   core_op, core_src, core_data, e.op, e.src, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d transactions outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cam_delta = '0; cam_ready = 1'b0; host_valid = 1'b0;
    host_op = 2'b00; host_delta = '0; core_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    n_cmp++;
    if ({core_valid, core_op, core_src, host_ready, busy} !== 6'b000010) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 000010",
               {core_valid, core_op, core_src, host_ready, busy});
    end
    #9 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (core_data !== '0 || event_count !== '0) begin
      n_err++;
      $display("FAIL reset_data: got data=%0h cnt=%0h, required 0/0", core_data, event_count);
    end
    n_cmp++;
    if ({core_valid, host_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_idle: got %b, required 010", {core_valid, host_ready, busy});
    end
  endtask

  task automatic test_single_cam();
    core_ready = 1'b1;
    sb.push_back('{op: 2'b00, data: 256'hA5, src: 1'b0});
    cam_delta = 256'hA5; cam_ready = 1'b1;
    tick();
    cam_ready = 1'b0; cam_delta = rnd();
    n_cmp++;
    if (core_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL cam_latency1: got valid=%b busy=%b, required 0/1", core_valid, busy);
    end
    tick();
    n_cmp++;
    if ({core_valid, core_op, core_src} !== 4'b1000 || core_data !== 256'hA5) begin
      n_err++;
      $display("FAIL cam_latency2: got valid=%b op=%0h src=%b data=%0h, required 1/0/0/a5",
               core_valid, core_op, core_src, core_data);
    end
    drain(10);
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL cam_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_host();
    core_ready = 1'b1;
    host_op = 2'b01; host_delta = 256'h1234; host_valid = 1'b1;
    n_cmp++;
    if (host_ready !== 1'b1) begin
      n_err++;
      $display("FAIL host_ready_pre: got %b, required 1", host_ready);
    end
    sb.push_back('{op: 2'b01, data: 256'h1234, src: 1'b1});
    tick();
    host_valid = 1'b0;
    n_cmp++;
    if (host_ready !== 1'b0) begin
      n_err++;
      $display("FAIL host_ready_busy: got %b, required 0", host_ready);
    end
    drain(10);
    n_cmp++;
    if (host_ready !== 1'b1) begin
      n_err++;
      $display("FAIL host_ready_post: got %b, required 1", host_ready);
    end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] c, h;
    core_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      c = rnd(); h = rnd();
      sb.push_back('{op: 2'b00, data: c, src: 1'b0});
      sb.push_back('{op: (r == 0) ? 2'b11 : 2'b10, data: h, src: 1'b1});
      cam_delta = c; cam_ready = 1'b1;
      host_delta = h; host_op = (r == 0) ? 2'b11 : 2'b10; host_valid = 1'b1;
      tick();
      cam_ready = 1'b0; host_valid = 1'b0;
      drain(20);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d;
    core_ready = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    sb.push_back('{op: 2'b00, data: 256'h77, src: 1'b0});
    cam_delta = 256'h77; cam_ready = 1'b1;
    tick();
    cam_ready = 1'b0;
    tick();
    cam_ready = 1'b1;
    cam_delta = 256'h3; tick();
    cam_delta = 256'h5; tick();
    cam_delta = 256'h6; tick();
    cam_ready = 1'b0;
`ifdef DELTA_COALESCE_EN
    exp_d = 256'h0;
`else
    exp_d = 256'h3;
`endif
    sb.push_back('{op: 2'b00, data: exp_d, src: 1'b0});
    n_cmp++;
    if (event_count !== 4'd2) begin
      n_err++;
      $display("FAIL ovf_count: got %0d, required 2", event_count);
    end
    n_cmp++;
    if (core_valid !== 1'b1 || core_data !== 256'h77) begin
      n_err++;
      $display("FAIL ovf_hold: got valid=%b data=%0h, required 1/77", core_valid, core_data);
    end
    core_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d, exp_d;
    core_ready = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_d = '0;
    for (int i = 0; i < 22; i++) begin
      d = rnd();
      if (i == 0) sb.push_back('{op: 2'b00, data: d, src: 1'b0});
      else if (i == 1) exp_d = d;
`ifdef DELTA_COALESCE_EN
      else exp_d = exp_d ^ d;
`endif
      cam_delta = d; cam_ready = 1'b1;
      tick();
      if (i == 8) begin
        n_cmp++;
        if (event_count !== 4'd7) begin
          n_err++;
          $display("FAIL sat_mid: got %0d, required 7", event_count);
        end
      end
    end
    n_cmp++;
    if (event_count !== 4'hF) begin
      n_err++;
      $display("FAIL sat_hold: got %0h, required f", event_count);
    end
    d = rnd();
`ifdef DELTA_COALESCE_EN
    exp_d = exp_d ^ d;
`endif
    cam_delta = d; cam_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cam_ready = 1'b0; cnt_clr = 1'b0;
    n_cmp++;
    if (event_count !== 4'h0) begin
      n_err++;
      $display("FAIL clr_priority: got %0h, required 0", event_count);
    end
    sb.push_back('{op: 2'b00, data: exp_d, src: 1'b0});
    core_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_back_to_back();
    int sent, cycles;
    logic [DW-1:0] d;
    core_ready = 1'b1;
    host_valid = 1'b1;
    sent = 0; cycles = 0;
    while (sent < 4 && cycles < 40) begin
      d = rnd();
      host_op = sent[1:0]; host_delta = d;
      if (host_ready) begin
        sb.push_back('{op: sent[1:0], data: d, src: 1'b1});
        sent++;
      end
      tick();
      cycles++;
    end
    host_valid = 1'b0;
    n_cmp++;
    if (cycles !== 7) begin
      n_err++;
      $display("FAIL b2b_rate: got %0d cycles for 4 host requests, required 7", cycles);
    end
    drain(20);
    sb.push_back('{op: 2'b00, data: '0, src: 1'b0});
    cam_delta = '0; cam_ready = 1'b1;
    tick();
    cam_ready = 1'b0;
    drain(10);
  endtask

  task automatic test_async_reset();
    core_ready = 1'b0;
    host_op = 2'b10; host_delta = rnd(); host_valid = 1'b1;
    sb.push_back('{op: 2'b10, data: host_delta, src: 1'b1});
    tick();
    host_valid = 1'b0;
    tick();
    n_cmp++;
    if (core_valid !== 1'b1 || core_src !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: got valid=%b src=%b, required 1/1", core_valid, core_src);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({core_valid, core_op, core_src, host_ready, busy} !== 6'b000010 ||
        core_data !== '0 || event_count !== '0) begin
      n_err++;
      $display("FAIL arst_now: got ctrl=%b data=%0h cnt=%0h, required 000010/0/0",
               {core_valid, core_op, core_src, host_ready, busy}, core_data, event_count);
    end
    sb.delete();
    rst_n = 1'b1;
    core_ready = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (busy !== 1'b0 || core_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_after: got busy=%b valid=%b, required 0/0", busy, core_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_cam();
    test_host();
    test_fairness();
    test_overflow();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_delta_scheduler.md
# video_delta_scheduler

Sequences the single delta-input port of the ATOMiK core between two requesters: the synthetic/DVP camera frame-delta source and the host command path. Each requester has a 1-entry holding register. The two are served round-robin over a valid/ready handshake to the core. The camera source has no backpressure, so overflow of its holding slot is resolved by XOR coalescing or by dropping (compile-time choice), with a saturating event counter.

## Interface
- DATA_WIDTH, 256, width of delta words
- CNT_WIDTH, 16, width of event counter
- clk  in  1  system clock; all state is sampled on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cam_delta  in  DATA_WIDTH  camera frame delta, valid only when cam_ready=1
- cam_ready  in  1  single-cycle strobe; no backpressure possible
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted when host_valid&&host_ready
- host_op  in  2  core opcode: 00 accumulate, 01 load, 10 read, 11 reserved (forwarded unchanged)
- host_delta  in  DATA_WIDTH  host operand
- core_valid  out  1  request to core
- core_ready  in  1  core accepts when core_valid&&core_ready
- core_op  out  2  opcode to core; camera grants always 00
- core_data  out  DATA_WIDTH  operand to core
- core_src  out  1  0=camera, 1=host; valid while core_valid
- event_count  out  CNT_WIDTH  saturating count of cam overflow events
- cnt_clr  in  1  synchronous clear of event_count
- busy  out  1  high when any slot is full or core_valid=1

## Operation
- Camera slot (cam_full, cam_buf):
  - cam_ready with slot empty or being freed this cycle: load cam_delta and set cam_full.
  - cam_ready with slot full and not freed this cycle: overflow; behaviour per Configuration; event_count+1.
- Host slot (host_full, host_buf, host_opbuf):
  - host_ready = !host_full (combinational from a register).
  - Accepted handshake loads the slot; it sets host_full on the next cycle.
- FSM states IDLE, GRANT_CAM, GRANT_HOST:
  - IDLE, both slots full: grant the requester not granted last. last_grant resets to host, so the camera wins first.
  - IDLE, one slot full: grant it.
  - On grant: copy the slot into core_data/core_op/core_src, clear that slot's full flag, assert core_valid, go to the GRANT_x state, update last_grant.
  - IDLE, nothing pending: stay in IDLE.
  - GRANT_x: hold outputs; when core_ready=1, drop core_valid and return to IDLE.
- An empty slot refilled during GRANT_x waits for the next IDLE decision.
- host_op 11 is forwarded untouched; the scheduler does not filter opcodes.
- An all-zero cam_delta is accepted like any other value.
- event_count saturates at all-ones and never wraps. cnt_clr has priority over a simultaneous increment (result 0).

## Timing
- Reset values: core_valid=0, core_op=00, core_data=0, core_src=0, host_ready=1, event_count=0, busy=0. State is IDLE, both slots empty, last_grant=host.
- Camera latency: cam_ready at edge N, slot full after N; core_valid high after edge N+1, assuming the FSM is idle and the host is not favoured.
- Host latency: handshake at edge N; core_valid high after N+1 under the same conditions.
- core_valid, core_op, core_data and core_src stay stable from assertion until the core_ready cycle.
- Minimum spacing is one IDLE bubble between core transactions, so peak throughput is 1 per 2 cycles when core_ready is held high.
- Freeing cam_full on the grant edge and cam_ready on that same edge: the new delta loads; this is not an overflow.
- Reset mid-transaction abandons the in-flight request; core_valid drops asynchronously.

## Configuration
- DELTA_COALESCE_EN defined:
  - On overflow, cam_buf <= cam_buf ^ cam_delta.
  - Since core accumulate is XOR, the merged delta is exactly equivalent to applying both.
  - event_count counts merges.
- DELTA_COALESCE_EN undefined:
  - On overflow, cam_delta is discarded and cam_buf keeps the older value.
  - event_count counts drops.

## Test plan
- Single camera delta: cam_ready with cam_delta=0x…A5, core_ready=1 → core_valid two cycles later, core_op=00, core_src=0, core_data=0x…A5; one transaction only.
- Host round trip: host_valid with op=01, delta=0x1234, core_ready=1 → host_ready low the next cycle; core sees op 01, data 0x1234, src=1; host_ready returns to 1.
- Fairness: both slots full in IDLE after reset, core_ready=1 → order is cam then host. Refill both → order is cam then host again (alternating from the last grant).
- Overflow: core_ready=0 while a camera grant is pending, then strobe 0x3, 0x5, 0x6 into the refilled slot → with DELTA_COALESCE_EN, next cam grant data = 0x3^0x5^0x6=0x0 and event_count=2; without it, data 0x3 and event_count=2.
- Counter saturation/clear: with CNT_WIDTH=4, force 20 overflows → event_count holds 0xF. cnt_clr together with an overflow → 0.
- Async reset asserted while in GRANT_HOST with core_ready=0 → all outputs return to reset values immediately; no transaction emitted after release.
